instr_mem_dp: RTL and testbench

Parametrised instruction memory for the Aiva core, replacing the 8-bit shared-bus instruction RAM. It has a loader write port with byte enables, an independent fetch read port with a valid strobe, and a selectable output register. After reset it clears its contents with a hardware sweep. It sits between the program loader (write side) and the fetch stage (read side) and has no tristate bus.

---
 rtl/instr_mem_dp.sv | 147 ++++++++++++++
 tb/tb_instr_mem_dp.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_dp.sv
// Dual-port instruction memory: byte-enabled loader write port, fetch read port
// with valid strobe, optional output register and a post-reset clear sweep.
module instr_mem_dp #(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    ADDR_WIDTH     = 8,
    parameter int                    OUT_REG        = 0,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    init_done
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int LANES = DATA_WIDTH / 8;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic [ADDR_WIDTH-1:0]   clr_cnt_nxt;
    logic                    sweep_we;
    logic                    wr_fire;
    logic                    rd_fire;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   s1_data;
    logic                    s1_valid;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= INIT;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        sweep_we    = 1'b0;
        case (state)
            INIT: begin
                if (CLEAR_ON_RESET != 0) begin
                    sweep_we    = 1'b1;
                    clr_cnt_nxt = clr_cnt + ADDR_WIDTH'(1);
                    if (clr_cnt == '1) begin
                        state_nxt = READY;
                    end
                end else begin
                    state_nxt = READY;
                end
            end
            READY: begin
                state_nxt = READY;
            end
            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    assign init_done = (state == READY);
    assign wr_fire   = (state == READY) && wr_en && !rst;
    assign rd_fire   = (state == READY) && rd_en && !rst;

    // NOTE: the storage array has no reset; clearing is done by the sweep so
    // the array can map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (sweep_we && !rst) begin
            mem[clr_cnt] <= CLEAR_VALUE;
        end else if (wr_fire) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Write-first bypass: enabled lanes of a same-address write override the stored bytes.
    always_comb begin
        rd_word = mem[rd_addr];
        for (int i = 0; i < LANES; i++) begin
            if (wr_fire && (wr_addr == rd_addr) && wr_be[i]) begin
                rd_word[8*i +: 8] = wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_fire;
            if (rd_fire) begin
                s1_data <= rd_word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] s2_data;
            logic                  s2_valid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign rd_data  = s2_data;
            assign rd_valid = s2_valid;
        end else begin : g_no_out_reg
            assign rd_data  = s1_data;
            assign rd_valid = s1_valid;
        end
    endgenerate

endmodule

// File: tb/tb_instr_mem_dp.sv
// Bench for instr_mem_dp: three instances (OUT_REG 0/1 with sweep, one without
// sweep) driven by shared directed and random stimulus, checked against a model.
module tb_instr_mem_dp;

    localparam int          DW    = 32;
    localparam int          AW    = 4;
    localparam int          DEPTH = 16;
    localparam logic [31:0] CLR   = 32'h0000_00A5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [3:0]    wr_be = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;

    logic [DW-1:0] rd_data0, rd_data1, rd_data2;
    logic          rd_valid0, rd_valid1, rd_valid2;
    logic          init_done0, init_done1, init_done2;

    instr_mem_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CLR)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0), .init_done(init_done0));

    instr_mem_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CLR)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1), .init_done(init_done1));

    instr_mem_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(0), .CLEAR_ON_RESET(0), .CLEAR_VALUE(CLR)) dut2 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data2), .rd_valid(rd_valid2), .init_done(init_done2));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory contents, count of rst-low edges, and a two-deep
    // delay line of accepted reads (tap 0 for OUT_REG=0, tap 1 for OUT_REG=1).
    logic [31:0] m_mem [DEPTH];
    int          m_cycles = 0;
    bit          m_started = 1'b0;
    bit          m_ready;
    bit          acc_v = 1'b0, prev_v = 1'b0, acc2_v = 1'b0;
    logic [31:0] acc_d = '0, prev_d = '0;
    bit          exp_v0 = 1'b0, exp_v1 = 1'b0;
    logic [31:0] exp_data0 = '0, exp_data1 = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_started = 1'b1;
            m_cycles  = 0;
            acc_v     = 1'b0;
            prev_v    = 1'b0;
            acc2_v    = 1'b0;
            exp_v0    = 1'b0;
            exp_v1    = 1'b0;
            exp_data0 = '0;
            exp_data1 = '0;
        end else begin
            m_ready = (m_cycles >= DEPTH);
            acc2_v  = rd_en && (m_cycles >= 1);
            prev_v  = acc_v;
            prev_d  = acc_d;
            acc_v   = 1'b0;
            if (m_ready) begin
                if (wr_en) begin
                    for (int i = 0; i < 4; i++) begin
                        if (wr_be[i]) m_mem[wr_addr][8*i +: 8] = wr_data[8*i +: 8];
                    end
                end
                if (rd_en) begin
                    acc_v = 1'b1;
                    acc_d = m_mem[rd_addr];
                end
            end
            if (m_cycles < 1000000) m_cycles++;
            if (m_cycles == DEPTH) begin
                for (int a = 0; a < DEPTH; a++) m_mem[a] = CLR;
            end
            exp_v0 = acc_v;
            if (acc_v) exp_data0 = acc_d;
            exp_v1 = prev_v;
            if (prev_v) exp_data1 = prev_d;
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            check("init_done0", init_done0, m_cycles >= DEPTH);
            check("init_done1", init_done1, m_cycles >= DEPTH);
            check("init_done2", init_done2, m_cycles >= 1);
            check("rd_valid0", rd_valid0, exp_v0);
            check("rd_valid1", rd_valid1, exp_v1);
            check("rd_valid2", rd_valid2, acc2_v);
            check("rd_data0", rd_data0, exp_data0);
            check("rd_data1", rd_data1, exp_data1);
        end
    end

    task automatic idle();
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] a);
        rd_en = 1'b1; rd_addr = a;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    // Counts negedges until init_done0 is seen, with random requests during INIT.
    task automatic wait_init(output int n);
        n = 0;
        while (!init_done0 && n < 40) begin
            wr_en   = 1'($urandom_range(0, 1));
            rd_en   = 1'($urandom_range(0, 1));
            wr_addr = 4'($urandom);
            rd_addr = 4'($urandom);
            wr_data = $urandom;
            wr_be   = 4'($urandom);
            @(negedge clk);
            n++;
        end
        idle();
    endtask

    int n;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_init(n);
        check("sweep_len", n, 16);

        for (int a = 0; a < DEPTH; a++) begin
            rd_en = 1'b1; rd_addr = 4'(a);
            @(negedge clk);
        end
        idle();
        repeat (3) @(negedge clk);
        check("sweep_hold0", rd_data0, 32'h0000_00A5);
        check("sweep_hold1", rd_data1, 32'h0000_00A5);

        do_write(4'd3, 32'h1122_3344, 4'hF);
        do_write(4'd3, 32'hAABB_CCDD, 4'h5);
        do_read(4'd3);
        repeat (2) @(negedge clk);
        check("be_merge0", rd_data0, 32'h11BB_33DD);
        check("be_merge1", rd_data1, 32'h11BB_33DD);

        do_write(4'd1, 32'h0101_0101, 4'hF);
        do_write(4'd2, 32'h0202_0202, 4'hF);
        rd_en = 1'b1; rd_addr = 4'd1;
        @(negedge clk);
        check("lat_v0_a", rd_valid0, 1); check("lat_d0_a", rd_data0, 32'h0101_0101);
        check("lat_v1_a", rd_valid1, 0);
        rd_addr = 4'd2;
        @(negedge clk);
        check("lat_d0_b", rd_data0, 32'h0202_0202);
        check("lat_v1_b", rd_valid1, 1); check("lat_d1_b", rd_data1, 32'h0101_0101);
        rd_addr = 4'd3;
        @(negedge clk);
        check("lat_d0_c", rd_data0, 32'h11BB_33DD); check("lat_d1_c", rd_data1, 32'h0202_0202);
        idle();
        @(negedge clk);
        check("lat_v0_d", rd_valid0, 0); check("lat_d0_d", rd_data0, 32'h11BB_33DD);
        check("lat_v1_d", rd_valid1, 1); check("lat_d1_d", rd_data1, 32'h11BB_33DD);
        @(negedge clk);
        check("lat_v1_e", rd_valid1, 0); check("lat_d1_e", rd_data1, 32'h11BB_33DD);

        do_write(4'd7, 32'h1234_5678, 4'hF);
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h0000_00FF; wr_be = 4'h1;
        rd_en = 1'b1; rd_addr = 4'd7;
        @(negedge clk);
        idle();
        check("collide0", rd_data0, 32'h1234_56FF);
        @(negedge clk);
        check("collide1", rd_data1, 32'h1234_56FF);

        rd_en = 1'b1; rd_addr = 4'd3;
        @(negedge clk);
        rd_en = 1'b0;
        rst = 1'b1;
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEAD_BEEF; wr_be = 4'hF;
        @(negedge clk);
        idle();
        check("midrst_v1", rd_valid1, 0);
        check("midrst_d1", rd_data1, 0);
        check("midrst_done", init_done0, 0);
        rst = 1'b0;
        wait_init(n);
        check("resweep_len", n, 16);
        do_read(4'd7);
        @(negedge clk);
        check("resweep_d1", rd_data1, 32'h0000_00A5);

        repeat (1500) begin
            rst     = ($urandom_range(0, 299) == 0);
            wr_en   = 1'($urandom_range(0, 1));
            rd_en   = 1'($urandom_range(0, 1));
            wr_addr = 4'($urandom);
            rd_addr = 4'($urandom);
            wr_data = $urandom;
            wr_be   = 4'($urandom);
            @(negedge clk);
        end
        rst = 1'b0;
        idle();
        repeat (20) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
